// File: rtl/otl_pkg.sv
// Shared definitions for the otl ADC/DAC data paths.
package otl_pkg;

  localparam int LANEW = 16;
  localparam int DROPW = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } lane_state_t;

endpackage

// File: rtl/otl_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a separate occupancy counter.
module otl_sync_fifo #(
  parameter int DATAW = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATAW-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [DATAW-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_fire;
  logic             rd_fire;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign rd_fire = rd_en & ~empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_fire = wr_en & (~full | rd_fire);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/otl_adc_packer.sv
// Packs pairs of ADC samples into 32-bit words and buffers them for the DMA stream.
module otl_adc_packer
  import otl_pkg::*;
#(
  parameter int SAMPW = 12,
  parameter int DATAW = 32,
  parameter int DEPTH = 16
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_areset,
  input  logic                   enable,
  input  logic [SAMPW-1:0]       adc_data,
  input  logic                   adc_valid,
  input  logic                   flush,
  input  logic                   ovf_clr,
  output logic [DATAW-1:0]       m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [DROPW-1:0]       drop_cnt
);

  lane_state_t      state, state_n;
  logic [LANEW-1:0] lane0, lane0_n;
  logic [LANEW-1:0] samp;
  logic             take;
  logic             wr_req;
  logic [DATAW-1:0] wr_word;
  logic             fifo_full;
  logic             fifo_empty;
  logic             rd;
  logic             drop;

  assign samp    = LANEW'(adc_data);
  assign take    = enable & adc_valid;
  assign m_valid = ~fifo_empty;
  assign rd      = m_valid & m_ready;
  assign drop    = wr_req & fifo_full & ~rd;

  always_comb begin
    state_n = state;
    lane0_n = lane0;
    wr_req  = 1'b0;
    wr_word = '0;
    case (state)
      ST_EMPTY: begin
        // A sample arriving with flush is emitted alone rather than held.
        if (take && flush) begin
          wr_req  = 1'b1;
          wr_word = {{LANEW{1'b0}}, samp};
        end else if (take) begin
          lane0_n = samp;
          state_n = ST_HALF;
        end
      end
      ST_HALF: begin
        if (take) begin
          wr_req  = 1'b1;
          wr_word = {samp, lane0};
          state_n = ST_EMPTY;
        end else if (flush) begin
          wr_req  = 1'b1;
          wr_word = {{LANEW{1'b0}}, lane0};
          state_n = ST_EMPTY;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state <= ST_EMPTY;
      lane0 <= '0;
    end else begin
      state <= state_n;
      lane0 <= lane0_n;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clr)
        drop_cnt <= DROPW'(1);
      else if (drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  otl_sync_fifo #(
    .DATAW (DATAW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (s_axi_aclk),
    .rst     (s_axi_areset),
    .wr_en   (wr_req),
    .wr_data (wr_word),
    .full    (fifo_full),
    .rd_en   (rd),
    .rd_data (m_data),
    .empty   (fifo_empty),
    .level   (level)
  );

endmodule

// File: tb/tb_otl_adc_packer.sv
// Self-checking bench for otl_adc_packer: directed scenarios plus a randomized queue-model run.
module tb_otl_adc_packer;

  localparam int SAMPW = 12;
  localparam int DATAW = 32;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic [SAMPW-1:0] adc_data = '0;
  logic             adc_valid = 1'b0;
  logic             flush = 1'b0;
  logic             ovf_clr = 1'b0;
  logic [DATAW-1:0] m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [LW-1:0]    level;
  logic             overflow;
  logic [15:0]      drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a queue of words plus the held half-word and status.
  logic [31:0] mq[$];
  bit          mheld;
  logic [15:0] mheld_v;
  bit          movf;
  int          mcnt;

  always #5 clk = ~clk;

  otl_adc_packer #(
    .SAMPW (SAMPW),
    .DATAW (DATAW),
    .DEPTH (DEPTH)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .enable       (enable),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .flush        (flush),
    .ovf_clr      (ovf_clr),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .level        (level),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt)
  );

  task automatic model_step();
    bit          rd, take, wr, drop;
    logic [31:0] w;
    logic [15:0] s;
    if (rst) begin
      mq.delete(); mheld = 0; mheld_v = '0; movf = 0; mcnt = 0;
      return;
    end
    s    = 16'(adc_data);
    take = enable && adc_valid;
    rd   = (mq.size() != 0) && m_ready;
    wr   = 0; w = '0; drop = 0;
    if (mheld) begin
      if (take)       begin wr = 1; w = {s, mheld_v};     mheld = 0; end
      else if (flush) begin wr = 1; w = {16'h0, mheld_v}; mheld = 0; end
    end else if (take) begin
      if (flush) begin wr = 1; w = {16'h0, s}; end
      else       begin mheld = 1; mheld_v = s; end
    end
    if (rd) void'(mq.pop_front());
    if (wr) begin
      if (mq.size() < DEPTH) mq.push_back(w);
      else drop = 1;
    end
    if (drop) begin
      movf = 1;
      mcnt = ovf_clr ? 1 : ((mcnt == 65535) ? 65535 : mcnt + 1);
    end else if (ovf_clr) begin
      movf = 0; mcnt = 0;
    end
  endtask

  task automatic cycle(input logic en, input logic v, input logic [SAMPW-1:0] d,
                       input logic fl, input logic clr, input logic rdy);
    enable = en; adc_valid = v; adc_data = d; flush = fl; ovf_clr = clr; m_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
    enable = 0; adc_valid = 0; flush = 0; ovf_clr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(0, 0, '0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors += 5;
    if (level !== '0) begin miscompares++; $display("FAIL reset_level got %0d want 0", level); end
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", m_valid); end
    if (m_data !== '0) begin miscompares++; $display("FAIL reset_data got %h want 0", m_data); end
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", overflow); end
    if (drop_cnt !== '0) begin miscompares++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_basic();
    do_reset();
    cycle(1, 1, 12'h123, 0, 0, 1);
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early got valid=%b want 0", m_valid); end
    cycle(1, 1, 12'h456, 0, 0, 1);
    vectors += 2;
    if (m_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b want 1", m_valid); end
    if (m_data !== 32'h04560123) begin miscompares++; $display("FAIL basic_data got %h want 04560123", m_data); end
    cycle(0, 0, '0, 0, 0, 1);
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL basic_one_cycle got valid=%b want 0", m_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    cycle(1, 1, 12'hABC, 0, 0, 0);
    cycle(1, 0, '0, 1, 0, 0);
    vectors += 2;
    if (m_data !== 32'h00000ABC) begin miscompares++; $display("FAIL flush_data got %h want 00000abc", m_data); end
    if (level !== LW'(1)) begin miscompares++; $display("FAIL flush_level got %0d want 1", level); end
    cycle(0, 0, '0, 0, 0, 1);
    cycle(1, 1, 12'h001, 0, 0, 0);
    cycle(1, 1, 12'h002, 0, 0, 0);
    vectors++;
    if (m_data !== 32'h00020001) begin miscompares++; $display("FAIL flush_relane got %h want 00020001", m_data); end
    // Flush of an empty lane and flush while enable is low
    cycle(0, 0, '0, 0, 0, 1);
    cycle(0, 0, '0, 1, 0, 0);
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL flush_empty got valid=%b want 0", m_valid); end
    cycle(1, 1, 12'h07E, 0, 0, 0);
    cycle(0, 1, 12'h555, 0, 0, 0);
    cycle(0, 0, '0, 1, 0, 0);
    vectors += 2;
    if (m_data !== 32'h0000007E) begin miscompares++; $display("FAIL flush_disabled got %h want 0000007e", m_data); end
    if (level !== LW'(1)) begin miscompares++; $display("FAIL flush_disabled_level got %0d want 1", level); end
  endtask

  task automatic test_simul();
    do_reset();
    cycle(1, 1, 12'h111, 0, 0, 0);
    cycle(1, 1, 12'h222, 1, 0, 0);
    vectors += 2;
    if (m_data !== 32'h02220111) begin miscompares++; $display("FAIL simul_data got %h want 02220111", m_data); end
    if (level !== LW'(1)) begin miscompares++; $display("FAIL simul_level got %0d want 1", level); end
    cycle(0, 0, '0, 0, 0, 1);
    vectors++;
    if (level !== '0) begin miscompares++; $display("FAIL simul_count got level=%0d want 0", level); end
    cycle(1, 1, 12'h333, 1, 0, 0);
    vectors++;
    if (m_data !== 32'h00000333) begin miscompares++; $display("FAIL simul_empty got %h want 00000333", m_data); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 36; k++) cycle(1, 1, SAMPW'(k), 0, 0, 0);
    vectors += 3;
    if (level !== LW'(16)) begin miscompares++; $display("FAIL ovf_level got %0d want 16", level); end
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b want 1", overflow); end
    if (drop_cnt !== 16'd2) begin miscompares++; $display("FAIL ovf_cnt got %0d want 2", drop_cnt); end
    cycle(0, 0, '0, 0, 1, 0);
    vectors += 2;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clr_flag got %b want 0", overflow); end
    if (drop_cnt !== '0) begin miscompares++; $display("FAIL ovf_clr_cnt got %0d want 0", drop_cnt); end
    for (int j = 0; j < 16; j++) begin
      vectors++;
      if (m_data !== {16'(2*j+1), 16'(2*j)})
        begin miscompares++; $display("FAIL ovf_drain[%0d] got %h want %h", j, m_data, {16'(2*j+1), 16'(2*j)}); end
      cycle(0, 0, '0, 0, 0, 1);
    end
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_drained got valid=%b want 0", m_valid); end
  endtask

  task automatic test_full_read();
    logic [31:0] exp_head;
    do_reset();
    for (int k = 0; k < 33; k++) cycle(1, 1, SAMPW'($urandom), 0, 0, 0);
    exp_head = mq[1];
    cycle(1, 1, SAMPW'($urandom), 0, 0, 1);
    vectors += 4;
    if (level !== LW'(16)) begin miscompares++; $display("FAIL fullrd_level got %0d want 16", level); end
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL fullrd_ovf got %b want 0", overflow); end
    if (drop_cnt !== '0) begin miscompares++; $display("FAIL fullrd_cnt got %0d want 0", drop_cnt); end
    if (m_data !== exp_head) begin miscompares++; $display("FAIL fullrd_head got %h want %h", m_data, exp_head); end
    for (int k = 0; k < 4; k++) cycle(1, 1, SAMPW'(k), 0, 0, 0);
    vectors++;
    if (drop_cnt !== 16'd2) begin miscompares++; $display("FAIL drop_cnt2 got %0d want 2", drop_cnt); end
    cycle(1, 1, 12'h0AA, 0, 0, 0);
    cycle(1, 1, 12'h0BB, 0, 1, 0);
    vectors += 2;
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL clr_drop_flag got %b want 1", overflow); end
    if (drop_cnt !== 16'd1) begin miscompares++; $display("FAIL clr_drop_cnt got %0d want 1", drop_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 11; k++) cycle(1, 1, SAMPW'(k + 100), 0, 0, 0);
    vectors++;
    if (level !== LW'(5)) begin miscompares++; $display("FAIL mid_pre_level got %0d want 5", level); end
    do_reset();
    vectors += 2;
    if (level !== '0) begin miscompares++; $display("FAIL mid_level got %0d want 0", level); end
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid got %b want 0", m_valid); end
    cycle(1, 1, 12'h5A5, 0, 0, 0);
    cycle(1, 1, 12'h0C3, 0, 0, 0);
    vectors++;
    if (m_data !== 32'h00C305A5) begin miscompares++; $display("FAIL mid_repack got %h want 00c305a5", m_data); end
  endtask

  task automatic test_random();
    int rdy_bias;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rdy_bias = ((c / 200) % 3 == 0) ? 10 : 70;
      rst = ($urandom_range(0, 399) == 0);
      cycle($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 60, SAMPW'($urandom),
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < rdy_bias);
      rst = 1'b0;
      vectors += 5;
      if (level !== LW'(mq.size()))
        begin miscompares++; $display("FAIL rnd_level c=%0d got %0d want %0d", c, level, mq.size()); end
      if (m_valid !== (mq.size() != 0))
        begin miscompares++; $display("FAIL rnd_valid c=%0d got %b want %b", c, m_valid, mq.size() != 0); end
      if (m_data !== ((mq.size() != 0) ? mq[0] : 32'h0))
        begin miscompares++; $display("FAIL rnd_data c=%0d got %h want %h", c, m_data, (mq.size() != 0) ? mq[0] : 32'h0); end
      if (overflow !== movf)
        begin miscompares++; $display("FAIL rnd_ovf c=%0d got %b want %b", c, overflow, movf); end
      if (drop_cnt !== 16'(mcnt))
        begin miscompares++; $display("FAIL rnd_cnt c=%0d got %0d want %0d", c, drop_cnt, mcnt); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_simul();
    test_overflow();
    test_full_read();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
